// File: rtl/crossbar_rr.sv
// N-master x M-slave request/ack crossbar: address-decoded slave select, one
// round-robin arbiter and transaction FSM per slave, per-transaction timeout.
module crossbar_rr #(
  parameter int N_MASTERS = 2,
  parameter int N_SLAVES  = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          master_req,
  input  logic [N_MASTERS-1:0]          master_cmd,
  input  logic [N_MASTERS*ADDR_W-1:0]   master_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   master_wdata,
  output logic [N_MASTERS*DATA_W-1:0]   master_rdata,
  output logic [N_MASTERS-1:0]          master_ack,
  output logic [N_MASTERS-1:0]          master_err,
  output logic [N_SLAVES-1:0]           slave_req,
  output logic [N_SLAVES-1:0]           slave_cmd,
  output logic [N_SLAVES*ADDR_W-1:0]    slave_addr,
  output logic [N_SLAVES*DATA_W-1:0]    slave_wdata,
  input  logic [N_SLAVES*DATA_W-1:0]    slave_rdata,
  input  logic [N_SLAVES-1:0]           slave_ack
);

  localparam int SEL_W = $clog2(N_SLAVES);
  localparam int MI_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e            state_q [N_SLAVES];
  state_e            state_d [N_SLAVES];
  logic [MI_W-1:0]   ptr_q   [N_SLAVES];
  logic [MI_W-1:0]   ptr_d   [N_SLAVES];
  logic [MI_W-1:0]   gnt_q   [N_SLAVES];
  logic [MI_W-1:0]   gnt_d   [N_SLAVES];
  logic [CNT_W-1:0]  cnt_q   [N_SLAVES];
  logic [CNT_W-1:0]  cnt_d   [N_SLAVES];

  logic [N_MASTERS*DATA_W-1:0] master_rdata_q, master_rdata_d;
  logic [N_MASTERS-1:0]        master_ack_q, master_ack_d;
  logic [N_MASTERS-1:0]        master_err_q, master_err_d;
  logic [N_SLAVES-1:0]         slave_req_q, slave_req_d;
  logic [N_SLAVES-1:0]         slave_cmd_q, slave_cmd_d;
  logic [N_SLAVES*ADDR_W-1:0]  slave_addr_q, slave_addr_d;
  logic [N_SLAVES*DATA_W-1:0]  slave_wdata_q, slave_wdata_d;

  logic [N_MASTERS-1:0] elig [N_SLAVES];

  always_comb begin
    for (int s = 0; s < N_SLAVES; s++) begin
      for (int m = 0; m < N_MASTERS; m++) begin
        elig[s][m] = master_req[m] &&
                     (master_addr[m*ADDR_W + ADDR_W - 1 -: SEL_W] == SEL_W'(s));
      end
    end
  end

  always_comb begin
    logic found;
    int   pick;
    int   idx;
    // NOTE: every variable gets a default before the case below, so no path leaves one unassigned and no latch is inferred.
    master_ack_d   = '0;
    master_err_d   = '0;
    master_rdata_d = master_rdata_q;
    slave_req_d    = slave_req_q;
    slave_cmd_d    = slave_cmd_q;
    slave_addr_d   = slave_addr_q;
    slave_wdata_d  = slave_wdata_q;
    for (int s = 0; s < N_SLAVES; s++) begin
      state_d[s] = state_q[s];
      ptr_d[s]   = ptr_q[s];
      gnt_d[s]   = gnt_q[s];
      cnt_d[s]   = cnt_q[s];
      found      = 1'b0;
      pick       = 0;
      case (state_q[s])
        S_IDLE: begin
          // Scan from the pointer so the last winner is considered last.
          for (int k = 0; k < N_MASTERS; k++) begin
            idx = (int'(ptr_q[s]) + k) % N_MASTERS;
            if (!found && elig[s][idx]) begin
              found = 1'b1;
              pick  = idx;
            end
          end
          if (found) begin
            gnt_d[s]       = MI_W'(pick);
            ptr_d[s]       = MI_W'((pick + 1) % N_MASTERS);
            cnt_d[s]       = '0;
            slave_req_d[s] = 1'b1;
            slave_cmd_d[s] = master_cmd[pick];
            slave_addr_d[s*ADDR_W +: ADDR_W]  = master_addr[pick*ADDR_W +: ADDR_W];
            slave_wdata_d[s*DATA_W +: DATA_W] = master_wdata[pick*DATA_W +: DATA_W];
            state_d[s]     = S_BUSY;
          end
        end
        S_BUSY: begin
          if (slave_ack[s]) begin
            master_ack_d[gnt_q[s]] = 1'b1;
            if (!slave_cmd_q[s]) begin
              master_rdata_d[int'(gnt_q[s])*DATA_W +: DATA_W] = slave_rdata[s*DATA_W +: DATA_W];
            end
            slave_req_d[s] = 1'b0;
            state_d[s]     = S_DONE;
          end else if (TIMEOUT != 0) begin
            if (cnt_q[s] == CNT_LAST) begin
              master_ack_d[gnt_q[s]] = 1'b1;
              master_err_d[gnt_q[s]] = 1'b1;
              slave_req_d[s]         = 1'b0;
              state_d[s]             = S_DONE;
            end else begin
              cnt_d[s] = cnt_q[s] + 1'b1;
            end
          end
        end
        S_DONE:  state_d[s] = S_IDLE;
        default: state_d[s] = S_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      master_rdata_q <= '0;
      master_ack_q   <= '0;
      master_err_q   <= '0;
      slave_req_q    <= '0;
      slave_cmd_q    <= '0;
      slave_addr_q   <= '0;
      slave_wdata_q  <= '0;
      for (int s = 0; s < N_SLAVES; s++) begin
        state_q[s] <= S_IDLE;
        ptr_q[s]   <= '0;
        gnt_q[s]   <= '0;
        cnt_q[s]   <= '0;
      end
    end else begin
      master_rdata_q <= master_rdata_d;
      master_ack_q   <= master_ack_d;
      master_err_q   <= master_err_d;
      slave_req_q    <= slave_req_d;
      slave_cmd_q    <= slave_cmd_d;
      slave_addr_q   <= slave_addr_d;
      slave_wdata_q  <= slave_wdata_d;
      for (int s = 0; s < N_SLAVES; s++) begin
        state_q[s] <= state_d[s];
        ptr_q[s]   <= ptr_d[s];
        gnt_q[s]   <= gnt_d[s];
        cnt_q[s]   <= cnt_d[s];
      end
    end
  end

  assign master_rdata = master_rdata_q;
  assign master_ack   = master_ack_q;
  assign master_err   = master_err_q;
  assign slave_req    = slave_req_q;
  assign slave_cmd    = slave_cmd_q;
  assign slave_addr   = slave_addr_q;
  assign slave_wdata  = slave_wdata_q;

endmodule
